// File: rtl/lab2_proc_mem_arb_pkg.sv
// Shared types for the processor imem/dmem-to-memory arbiter: port ids and
// the 4-byte memory request/response message formats.
package lab2_proc_mem_arb_pkg;

    typedef logic arb_port_t;

    localparam arb_port_t PORT_IMEM = 1'b0;
    localparam arb_port_t PORT_DMEM = 1'b1;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [7:0]  opaque;
        logic [2:0]  type_;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [7:0]  opaque;
        logic [2:0]  type_;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/lab2_proc_mem_arb_tracker.sv
// In-order FIFO of source port ids for requests issued to memory but not yet
// answered; the head id steers the next memory response.
module lab2_proc_mem_arb_tracker
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int unsigned p_depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_i,
    input  arb_port_t                enq_id_i,
    input  logic                     deq_i,
    output logic                     full_o,
    output logic                     empty_o,
    output arb_port_t                head_o,
    output logic [$clog2(p_depth):0] count_o
);

    localparam int unsigned AW       = $clog2(p_depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(p_depth);

    logic [p_depth-1:0] ids_q, ids_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               do_enq, do_deq;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = ids_q[rd_ptr_q];
    assign count_o = count_q;

    // Guarded so the count can never leave [0, p_depth] even on misuse.
    assign do_enq = enq_i & ~full_o;
    assign do_deq = deq_i & ~empty_o;

    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) begin
            ids_d[wr_ptr_q] = enq_id_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_enq && !do_deq) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Round-robin merge of the processor imem/dmem request streams onto one memory
// port, with in-order routing of memory responses back to their source.
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int unsigned p_max_inflight = 4
) (
    input  logic                            clk,
    input  logic                            reset,

    input  mem_req_4B_t                     imem_reqstream_msg,
    input  logic                            imem_reqstream_val,
    output logic                            imem_reqstream_rdy,
    output mem_resp_4B_t                    imem_respstream_msg,
    output logic                            imem_respstream_val,
    input  logic                            imem_respstream_rdy,

    input  mem_req_4B_t                     dmem_reqstream_msg,
    input  logic                            dmem_reqstream_val,
    output logic                            dmem_reqstream_rdy,
    output mem_resp_4B_t                    dmem_respstream_msg,
    output logic                            dmem_respstream_val,
    input  logic                            dmem_respstream_rdy,

    output mem_req_4B_t                     mem_reqstream_msg,
    output logic                            mem_reqstream_val,
    input  logic                            mem_reqstream_rdy,
    input  mem_resp_4B_t                    mem_respstream_msg,
    input  logic                            mem_respstream_val,
    output logic                            mem_respstream_rdy,

    output logic [$clog2(p_max_inflight):0] num_inflight
);

    logic      rst_dly_q;
    arb_port_t prio_q, prio_d;

    logic      trk_full, trk_empty;
    arb_port_t trk_head;

    logic      active;
    logic      prio_val;
    arb_port_t grant;
    logic      can_issue_any;
    logic      req_fire;
    logic      resp_route;
    logic      resp_fire;

    // Held high by reset and for one cycle after release; gates every handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_dly_q <= 1'b1;
        end else begin
            rst_dly_q <= 1'b0;
        end
    end

    assign active = ~rst_dly_q;

    assign prio_val = (prio_q == PORT_DMEM) ? dmem_reqstream_val : imem_reqstream_val;
    assign grant    = prio_val ? prio_q : other_port(prio_q);

    assign can_issue_any     = active & ~trk_full;
    assign mem_reqstream_val = can_issue_any & (imem_reqstream_val | dmem_reqstream_val);
    assign mem_reqstream_msg = (grant == PORT_DMEM) ? dmem_reqstream_msg : imem_reqstream_msg;

    assign imem_reqstream_rdy = can_issue_any & mem_reqstream_rdy & imem_reqstream_val
                              & (grant == PORT_IMEM);
    assign dmem_reqstream_rdy = can_issue_any & mem_reqstream_rdy & dmem_reqstream_val
                              & (grant == PORT_DMEM);

    assign req_fire = mem_reqstream_val & mem_reqstream_rdy;
    assign prio_d   = req_fire ? other_port(grant) : prio_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PORT_IMEM;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign resp_route = active & ~trk_empty;

    assign imem_respstream_msg = mem_respstream_msg;
    assign dmem_respstream_msg = mem_respstream_msg;
    assign imem_respstream_val = resp_route & (trk_head == PORT_IMEM) & mem_respstream_val;
    assign dmem_respstream_val = resp_route & (trk_head == PORT_DMEM) & mem_respstream_val;
    assign mem_respstream_rdy  = resp_route & ((trk_head == PORT_DMEM) ? dmem_respstream_rdy
                                                                       : imem_respstream_rdy);

    assign resp_fire = mem_respstream_val & mem_respstream_rdy;

    lab2_proc_mem_arb_tracker #(
        .p_depth (p_max_inflight)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .enq_i    (req_fire),
        .enq_id_i (grant),
        .deq_i    (resp_fire),
        .full_o   (trk_full),
        .empty_o  (trk_empty),
        .head_o   (trk_head),
        .count_o  (num_inflight)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_respstream_val && trk_empty && active))
            else $error("lab2_proc_mem_arbiter: memory response with no request in flight");
        end
    end

endmodule
